// File: rtl/nios2_pkg.sv
// Shared definitions for the nios_2 core front end: default widths,
// fetch sequencer state encoding and the bubble instruction.
package nios2_pkg;

  localparam int unsigned DEF_PC_W   = 8;
  localparam int unsigned DEF_INST_W = 32;

  // add r0, r0, r0
  localparam logic [31:0] NOP_INST = 32'h0001_883a;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/nios2_fetch_fifo.sv
// Two-entry prefetch queue of {pc, inst}; entry 0 is always the head,
// so the head is presented straight from a register. Flush beats push/pop.
module nios2_fetch_fifo #(
  parameter int unsigned DW = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [1:0]    count
);

  logic [DW-1:0] r_ent0;
  logic [DW-1:0] r_ent1;
  logic [1:0]    r_count;
  logic          w_pop;
  logic          w_push;

  assign w_pop  = pop & (r_count != 2'd0);
  assign w_push = push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_ent0 <= din;
          else                 r_ent1 <= din;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_ent0  <= r_ent1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Count stays the same; the new word lands behind whatever remains.
          if (r_count == 2'd1) begin
            r_ent0 <= din;
          end else begin
            r_ent0 <= r_ent1;
            r_ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = r_ent0;
  assign full  = (r_count == 2'd2);
  assign empty = (r_count == 2'd0);
  assign count = r_count;

endmodule

// File: rtl/nios2_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one request at a
// time to instruction memory and feeds decode through a 2-entry queue.
module nios2_fetch_ctrl
  import nios2_pkg::*;
#(
  parameter int unsigned PC_W     = DEF_PC_W,
  parameter int unsigned INST_W   = DEF_INST_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   prog_count_o
);

  localparam int unsigned DW = PC_W + INST_W;

  fetch_state_e    r_state;
  logic [PC_W-1:0] r_fetch_pc;
  logic            r_req;
  logic [PC_W-1:0] r_addr;

  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [1:0]      w_count;
  logic [1:0]      w_cnt_after;
  logic [DW-1:0]   w_dout;

  // Only words from a live (non-draining) request that is not being redirected are kept.
  assign w_push      = (r_state == ST_REQ) & imem_ack & ~redirect;
  assign w_pop       = inst_valid & inst_ready;
  assign w_cnt_after = w_count + 2'(w_push) - 2'(w_pop);

  nios2_fetch_fifo #(.DW(DW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect),
    .din   ({imem_addr, imem_data}),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= PC_W'(RESET_PC);
      r_req      <= 1'b0;
      r_addr     <= PC_W'(RESET_PC);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (redirect) begin
            r_fetch_pc <= redirect_pc;
          end else if (enable && !w_full) begin
            r_state    <= ST_REQ;
            r_req      <= 1'b1;
            r_addr     <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + PC_W'(1);
          end
        end
        ST_REQ: begin
          if (redirect) begin
            r_fetch_pc <= redirect_pc;
            if (imem_ack) begin
              r_state <= ST_IDLE;
              r_req   <= 1'b0;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else if (imem_ack) begin
            if (enable && (w_cnt_after < 2'd2)) begin
              r_addr     <= r_fetch_pc;
              r_fetch_pc <= r_fetch_pc + PC_W'(1);
            end else begin
              r_state <= ST_IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          // Old request must still complete; its data is thrown away.
          if (redirect) r_fetch_pc <= redirect_pc;
          if (imem_ack) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req     = r_req;
  assign imem_addr    = r_addr;
  assign prog_count_o = r_fetch_pc;
  assign inst_valid   = ~w_empty;
  assign inst_pc      = w_dout[DW-1 -: PC_W];
  assign inst_o       = w_dout[INST_W-1:0];

endmodule
